// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to a combinational imem and
// registers the returned word (or fetch fault) into the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_en,
   input  logic [63:0] redirect_pc,
   input  logic        trap_en,
   input  logic [63:0] trap_pc,
   output logic [63:0] pc_addr,
   input  logic [31:0] imem_instr,
   input  logic        imem_exc_en,
   input  logic [3:0]  imem_exc_code,
   input  logic [63:0] imem_exc_val,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_exc_en,
   output logic [3:0]  if_exc_code,
   output logic [63:0] if_exc_val
);

   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_RUN   = 2'd1;
   localparam logic [1:0]  ST_FAULT = 2'd2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic [63:0] pc_q, pc_d;
   logic [1:0]  state_q, state_d;
   logic        mis_q, mis_d;
   logic        vld_q, vld_d;
   logic [63:0] ifpc_q, ifpc_d;
   logic [31:0] instr_q, instr_d;
   logic        exc_q, exc_d;
   logic [3:0]  code_q, code_d;
   logic [63:0] val_q, val_d;

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      mis_d   = mis_q;
      vld_d   = vld_q;
      ifpc_d  = ifpc_q;
      instr_d = instr_q;
      exc_d   = exc_q;
      code_d  = code_q;
      val_d   = val_q;
      if (trap_en || redirect_en) begin
         // Flush the slot; a misaligned redirect target faults on the next fetch
         pc_d    = trap_en ? trap_pc : redirect_pc;
         mis_d   = trap_en ? 1'b0 : (redirect_pc[1:0] != 2'b00);
         state_d = ST_RUN;
         vld_d   = 1'b0;
         instr_d = NOP;
         exc_d   = 1'b0;
         code_d  = 4'd0;
         val_d   = 64'd0;
      end else if (!stall_i) begin
         case (state_q)
            ST_RUN: begin
               vld_d  = 1'b1;
               ifpc_d = pc_q;
               if (mis_q) begin
                  instr_d = NOP;
                  exc_d   = 1'b1;
                  code_d  = 4'd0;
                  val_d   = pc_q;
                  mis_d   = 1'b0;
                  state_d = ST_FAULT;
               end else if (imem_exc_en) begin
                  instr_d = NOP;
                  exc_d   = 1'b1;
                  code_d  = imem_exc_code;
                  val_d   = imem_exc_val;
                  state_d = ST_FAULT;
               end else begin
                  instr_d = imem_instr;
                  exc_d   = 1'b0;
                  code_d  = 4'd0;
                  val_d   = 64'd0;
                  pc_d    = pc_q + 64'd4;
               end
            end
            default: begin
               // IDLE and FAULT_WAIT both emit bubbles; only IDLE moves on by itself
               vld_d   = 1'b0;
               instr_d = NOP;
               exc_d   = 1'b0;
               code_d  = 4'd0;
               val_d   = 64'd0;
               if (state_q == ST_IDLE) state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= ST_IDLE;
         mis_q   <= 1'b0;
         vld_q   <= 1'b0;
         ifpc_q  <= 64'd0;
         instr_q <= NOP;
         exc_q   <= 1'b0;
         code_q  <= 4'd0;
         val_q   <= 64'd0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         mis_q   <= mis_d;
         vld_q   <= vld_d;
         ifpc_q  <= ifpc_d;
         instr_q <= instr_d;
         exc_q   <= exc_d;
         code_q  <= code_d;
         val_q   <= val_d;
      end
   end

   assign pc_addr     = pc_q;
   assign if_valid    = vld_q;
   assign if_pc       = ifpc_q;
   assign if_instr    = instr_q;
   assign if_exc_en   = exc_q;
   assign if_exc_code = code_q;
   assign if_exc_val  = val_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a behavioural model of the fetch unit and a 2048-word instruction memory.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_en = 1'b0;
   logic [63:0] redirect_pc = 64'd0;
   logic        trap_en = 1'b0;
   logic [63:0] trap_pc = 64'd0;
   logic [63:0] pc_addr;
   logic [31:0] imem_instr;
   logic        imem_exc_en;
   logic [3:0]  imem_exc_code;
   logic [63:0] imem_exc_val;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_exc_en;
   logic [3:0]  if_exc_code;
   logic [63:0] if_exc_val;

   logic [31:0] mem [0:2047];
   logic        glitch = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   // Behavioural model: phase 0 = just out of reset, 1 = fetching, 2 = halted on fault
   int          m_phase;
   logic [63:0] m_pc;
   logic        m_mis;
   logic        m_v;
   logic [63:0] m_ipc;
   logic [31:0] m_ins;
   logic        m_exc;
   logic [3:0]  m_code;
   logic [63:0] m_val;

   fetch_stage #(.RESET_PC(64'h0)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .trap_en(trap_en), .trap_pc(trap_pc),
      .pc_addr(pc_addr),
      .imem_instr(imem_instr), .imem_exc_en(imem_exc_en),
      .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .if_exc_en(if_exc_en), .if_exc_code(if_exc_code), .if_exc_val(if_exc_val)
   );

   always #5 clk = ~clk;

   // Memory covers 0x0..0x1FFF; anything above faults with an access fault
   assign imem_instr    = (pc_addr < 64'h2000) ? mem[pc_addr[12:2]] : 32'h0;
   assign imem_exc_en   = (pc_addr >= 64'h2000) || glitch;
   assign imem_exc_code = 4'd1;
   assign imem_exc_val  = pc_addr;

   task automatic model_edge();
      logic        in_range;
      logic        acc_fault;
      in_range  = (m_pc < 64'h2000);
      acc_fault = !in_range || glitch;
      if (rst) begin
         m_pc = 64'h0; m_phase = 0; m_mis = 1'b0;
         m_v = 1'b0; m_ipc = 64'h0; m_ins = 32'h13; m_exc = 1'b0; m_code = 4'd0; m_val = 64'd0;
      end else if (trap_en || redirect_en) begin
         m_pc    = trap_en ? trap_pc : redirect_pc;
         m_mis   = !trap_en && (redirect_pc % 4 != 0);
         m_phase = 1;
         m_v = 1'b0; m_ins = 32'h13; m_exc = 1'b0;
      end else if (!stall_i) begin
         if (m_phase == 1) begin
            m_v = 1'b1; m_ipc = m_pc;
            if (m_mis) begin
               m_ins = 32'h13; m_exc = 1'b1; m_code = 4'd0; m_val = m_pc; m_mis = 1'b0; m_phase = 2;
            end else if (acc_fault) begin
               m_ins = 32'h13; m_exc = 1'b1; m_code = 4'd1; m_val = m_pc; m_phase = 2;
            end else begin
               m_ins = mem[m_pc[12:2]]; m_exc = 1'b0; m_pc = m_pc + 64'd4;
            end
         end else begin
            m_v = 1'b0; m_ins = 32'h13; m_exc = 1'b0;
            if (m_phase == 0) m_phase = 1;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      n_checks += 7;
      if (pc_addr !== 64'h0)    begin n_fail++; $display("FAIL reset_pc_addr got %h want 0", pc_addr); end
      if (if_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b want 0", if_valid); end
      if (if_pc !== 64'h0)      begin n_fail++; $display("FAIL reset_if_pc got %h want 0", if_pc); end
      if (if_instr !== 32'h13)  begin n_fail++; $display("FAIL reset_instr got %h want 13", if_instr); end
      if (if_exc_en !== 1'b0)   begin n_fail++; $display("FAIL reset_exc_en got %b want 0", if_exc_en); end
      if (if_exc_code !== 4'd0) begin n_fail++; $display("FAIL reset_exc_code got %h want 0", if_exc_code); end
      if (if_exc_val !== 64'h0) begin n_fail++; $display("FAIL reset_exc_val got %h want 0", if_exc_val); end
   endtask

   task automatic test_fetch();
      rst = 1'b0;
      cyc();
      n_checks += 2;
      if (if_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", if_valid); end
      if (pc_addr !== 64'h0) begin n_fail++; $display("FAIL idle_pc_addr got %h want 0", pc_addr); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_checks += 3;
         if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid[%0d] got %b want 1", i, if_valid); end
         if (if_pc !== 64'(i * 4)) begin n_fail++; $display("FAIL fetch_pc[%0d] got %h want %h", i, if_pc, i * 4); end
         if (if_instr !== mem[i]) begin n_fail++; $display("FAIL fetch_instr[%0d] got %h want %h", i, if_instr, mem[i]); end
      end
   endtask

   task automatic test_stall();
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks += 3;
         if (pc_addr !== 64'h8) begin n_fail++; $display("FAIL stall_pc_addr[%0d] got %h want 8", i, pc_addr); end
         if (if_pc !== 64'h4)   begin n_fail++; $display("FAIL stall_if_pc[%0d] got %h want 4", i, if_pc); end
         if (if_instr !== mem[1]) begin n_fail++; $display("FAIL stall_instr[%0d] got %h want %h", i, if_instr, mem[1]); end
      end
      stall_i = 1'b0;
      cyc();
      n_checks += 2;
      if (if_pc !== 64'h8)     begin n_fail++; $display("FAIL resume_if_pc got %h want 8", if_pc); end
      if (if_instr !== mem[2]) begin n_fail++; $display("FAIL resume_instr got %h want %h", if_instr, mem[2]); end
   endtask

   task automatic test_redirect_stall();
      stall_i = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h100;
      cyc();
      stall_i = 1'b0; redirect_en = 1'b0;
      n_checks += 3;
      if (if_valid !== 1'b0)   begin n_fail++; $display("FAIL redir_bubble_valid got %b want 0", if_valid); end
      if (if_instr !== 32'h13) begin n_fail++; $display("FAIL redir_bubble_instr got %h want 13", if_instr); end
      if (pc_addr !== 64'h100) begin n_fail++; $display("FAIL redir_pc_addr got %h want 100", pc_addr); end
      cyc();
      n_checks += 3;
      if (if_valid !== 1'b1)     begin n_fail++; $display("FAIL redir_valid got %b want 1", if_valid); end
      if (if_pc !== 64'h100)     begin n_fail++; $display("FAIL redir_if_pc got %h want 100", if_pc); end
      if (if_instr !== mem[64])  begin n_fail++; $display("FAIL redir_instr got %h want %h", if_instr, mem[64]); end
   endtask

   task automatic test_access_fault();
      redirect_en = 1'b1; redirect_pc = 64'h1FF0;
      cyc();
      redirect_en = 1'b0;
      for (int k = 0; k < 20 && !if_exc_en; k++) cyc();
      n_checks += 5;
      if (if_exc_en !== 1'b1)       begin n_fail++; $display("FAIL acc_exc_en got %b want 1", if_exc_en); end
      if (if_exc_code !== 4'd1)     begin n_fail++; $display("FAIL acc_code got %h want 1", if_exc_code); end
      if (if_exc_val !== 64'h2000)  begin n_fail++; $display("FAIL acc_val got %h want 2000", if_exc_val); end
      if (if_instr !== 32'h13)      begin n_fail++; $display("FAIL acc_instr got %h want 13", if_instr); end
      if (if_valid !== 1'b1)        begin n_fail++; $display("FAIL acc_valid got %b want 1", if_valid); end
      for (int i = 0; i < 4; i++) begin
         glitch = 1'($urandom_range(0, 1));
         cyc();
         n_checks += 3;
         if (if_valid !== 1'b0)    begin n_fail++; $display("FAIL accwait_valid[%0d] got %b want 0", i, if_valid); end
         if (if_exc_en !== 1'b0)   begin n_fail++; $display("FAIL accwait_exc[%0d] got %b want 0", i, if_exc_en); end
         if (pc_addr !== 64'h2000) begin n_fail++; $display("FAIL accwait_pc[%0d] got %h want 2000", i, pc_addr); end
      end
      glitch = 1'b0;
      trap_en = 1'b1; trap_pc = 64'h80;
      cyc();
      trap_en = 1'b0;
      cyc();
      n_checks += 2;
      if (if_valid !== 1'b1) begin n_fail++; $display("FAIL trap_valid got %b want 1", if_valid); end
      if (if_pc !== 64'h80)  begin n_fail++; $display("FAIL trap_if_pc got %h want 80", if_pc); end
   endtask

   task automatic test_misalign();
      redirect_en = 1'b1; redirect_pc = 64'h102;
      cyc();
      redirect_en = 1'b0;
      n_checks += 1;
      if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_bubble_valid got %b want 0", if_valid); end
      cyc();
      n_checks += 4;
      if (if_exc_en !== 1'b1)     begin n_fail++; $display("FAIL mis_exc_en got %b want 1", if_exc_en); end
      if (if_exc_code !== 4'd0)   begin n_fail++; $display("FAIL mis_code got %h want 0", if_exc_code); end
      if (if_exc_val !== 64'h102) begin n_fail++; $display("FAIL mis_val got %h want 102", if_exc_val); end
      if (if_pc !== 64'h102)      begin n_fail++; $display("FAIL mis_if_pc got %h want 102", if_pc); end
      for (int i = 0; i < 3; i++) begin
         glitch = 1'($urandom_range(0, 1));
         cyc();
         n_checks += 2;
         if (if_valid !== 1'b0)   begin n_fail++; $display("FAIL miswait_valid[%0d] got %b want 0", i, if_valid); end
         if (pc_addr !== 64'h102) begin n_fail++; $display("FAIL miswait_pc[%0d] got %h want 102", i, pc_addr); end
      end
      glitch = 1'b0;
      trap_en = 1'b1; trap_pc = 64'h80;
      cyc();
      trap_en = 1'b0;
      cyc();
      n_checks += 1;
      if (if_pc !== 64'h80) begin n_fail++; $display("FAIL mistrap_if_pc got %h want 80", if_pc); end
   endtask

   task automatic test_priority();
      trap_en = 1'b1; trap_pc = 64'h80; redirect_en = 1'b1; redirect_pc = 64'h200;
      cyc();
      trap_en = 1'b0; redirect_en = 1'b0;
      n_checks += 1;
      if (pc_addr !== 64'h80) begin n_fail++; $display("FAIL prio_pc_addr got %h want 80", pc_addr); end
      cyc(); cyc();
      rst = 1'b1; stall_i = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h300;
      cyc();
      rst = 1'b0; stall_i = 1'b0; redirect_en = 1'b0;
      n_checks += 4;
      if (pc_addr !== 64'h0)   begin n_fail++; $display("FAIL midrst_pc_addr got %h want 0", pc_addr); end
      if (if_valid !== 1'b0)   begin n_fail++; $display("FAIL midrst_valid got %b want 0", if_valid); end
      if (if_pc !== 64'h0)     begin n_fail++; $display("FAIL midrst_if_pc got %h want 0", if_pc); end
      if (if_instr !== 32'h13) begin n_fail++; $display("FAIL midrst_instr got %h want 13", if_instr); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         stall_i     = ($urandom_range(0, 99) < 25);
         redirect_en = ($urandom_range(0, 99) < 6);
         trap_en     = ($urandom_range(0, 99) < 3);
         rst         = ($urandom_range(0, 199) == 0);
         redirect_pc = 64'($urandom_range(0, 32'h2040)) & ~64'h3;
         if ($urandom_range(0, 9) == 0) redirect_pc = redirect_pc | 64'($urandom_range(1, 3));
         trap_pc     = 64'($urandom_range(0, 32'h1F00)) & ~64'h3;
         glitch      = (m_phase == 2) && ($urandom_range(0, 1) == 1);
         cyc();
         n_checks += 4;
         if (pc_addr !== m_pc)   begin n_fail++; $display("FAIL rnd_pc_addr[%0d] got %h want %h", i, pc_addr, m_pc); end
         if (if_valid !== m_v)   begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, if_valid, m_v); end
         if (if_instr !== m_ins) begin n_fail++; $display("FAIL rnd_instr[%0d] got %h want %h", i, if_instr, m_ins); end
         if (if_exc_en !== m_exc) begin n_fail++; $display("FAIL rnd_exc[%0d] got %b want %b", i, if_exc_en, m_exc); end
         if (m_v) begin
            n_checks += 1;
            if (if_pc !== m_ipc) begin n_fail++; $display("FAIL rnd_if_pc[%0d] got %h want %h", i, if_pc, m_ipc); end
         end
         if (m_v && m_exc) begin
            n_checks += 2;
            if (if_exc_code !== m_code) begin n_fail++; $display("FAIL rnd_code[%0d] got %h want %h", i, if_exc_code, m_code); end
            if (if_exc_val !== m_val)   begin n_fail++; $display("FAIL rnd_val[%0d] got %h want %h", i, if_exc_val, m_val); end
         end
      end
      rst = 1'b0; stall_i = 1'b0; redirect_en = 1'b0; trap_en = 1'b0; glitch = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = $urandom;
      m_phase = 0; m_pc = 64'h0; m_mis = 1'b0; m_v = 1'b0; m_ipc = 64'h0;
      m_ins = 32'h13; m_exc = 1'b0; m_code = 4'd0; m_val = 64'h0;
      #2;
      test_reset();
      test_fetch();
      test_stall();
      test_redirect_stall();
      test_access_fault();
      test_misalign();
      test_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
